// File: rtl/wr_en_decoder_pkg.sv
// Shared constants, address type and one-hot helper for the write-enable decoder.
// Optional build macro used by the top: WR_EN_DECODER_RR_ARB_EN (round-robin arbitration).
package wr_en_decoder_pkg;

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_NUM_REGS  = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // One-hot image of a register address at the default address width.
  function automatic logic [DEF_NUM_REGS-1:0] onehot_decode(input reg_addr_t addr);
    logic [DEF_NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/addr_onehot_dec.sv
// Combinational ADDR_W -> 2**ADDR_W one-hot decoder with enable; all zeros when disabled.
module addr_onehot_dec
  import wr_en_decoder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(2**ADDR_W)-1:0]   onehot
);

  if (ADDR_W == DEF_ADDR_W) begin : g_pkg
    // Default width: reuse the shared package helper.
    always_comb begin
      if (en) begin
        onehot = onehot_decode(addr);
      end else begin
        onehot = '0;
      end
    end
  end else begin : g_gen
    // Any other width: set the addressed bit directly.
    always_comb begin
      onehot = '0;
      if (en) begin
        onehot[addr] = 1'b1;
      end else begin
        onehot = '0;
      end
    end
  end

endmodule

// File: rtl/wr_en_decoder_arb.sv
// Registered multi-port write-enable decoder for the register file.
// Same-address requests are arbitrated (losers see req_ready=0); accepted
// requests produce a one-cycle one-hot enable in the following cycle.
// Build macro WR_EN_DECODER_RR_ARB_EN selects round-robin arbitration with a
// head pointer; without it the lowest port index always wins.
module wr_en_decoder_arb
  import wr_en_decoder_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS*(2**ADDR_W)-1:0]  en_out,
  output logic [(2**ADDR_W)-1:0]            we_any,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  conflict_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ADDR_W-1:0]             addr_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]          ready_s;
  logic [NUM_PORTS-1:0]          accept_s;
  logic [NUM_PORTS-1:0]          dec_en_s;
  logic                          stall_any_s;
  logic [NUM_PORTS*NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0]           we_s;
  logic [NUM_PORTS*NUM_REGS-1:0] en_r;
  logic [NUM_REGS-1:0]           we_r;
  logic [CNT_W-1:0]              cnt_r;

`ifdef WR_EN_DECODER_RR_ARB_EN
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  logic [PTR_W-1:0]     ptr_r;
  logic [PTR_W-1:0]     ptr_next_s;
  logic                 win_found_s;
  logic [NUM_PORTS-1:0] share_s;
`endif

  // Position of port q in the priority order that starts at port head (0 = highest).
  function automatic int prio_rank(input int q, input int head);
    return (q + NUM_PORTS - head) % NUM_PORTS;
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign addr_s[g] = req_addr[g*ADDR_W +: ADDR_W];

    addr_onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .en     (dec_en_s[g]),
      .addr   (addr_s[g]),
      .onehot (dec_s[g*NUM_REGS +: NUM_REGS])
    );
  end

  // Arbitration: a valid port stalls when a higher-priority valid port targets the same register.
  always_comb begin
    int   head;
    logic same;
    head    = 0;
`ifdef WR_EN_DECODER_RR_ARB_EN
    head    = int'(ptr_r);
    share_s = '0;
`endif
    ready_s = '1;
    same    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        same = (q != p) && req_valid[p] && req_valid[q] && (addr_s[p] == addr_s[q]);
        ready_s[p] = ready_s[p] & ~(same && (prio_rank(q, head) < prio_rank(p, head)));
`ifdef WR_EN_DECODER_RR_ARB_EN
        share_s[p] = share_s[p] | same;
`endif
      end
    end
  end

  // Acceptance, stall detection and decoder enables ($zero writes are accepted but silent).
  always_comb begin
    accept_s    = req_valid & ready_s;
    stall_any_s = |(req_valid & ~ready_s);
    dec_en_s    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dec_en_s[p] = accept_s[p] && !((ZERO_REG != 0) && (addr_s[p] == '0));
    end
  end

  // Per-register strobe: OR of every port's decoded slice.
  always_comb begin
    we_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      we_s = we_s | dec_s[p*NUM_REGS +: NUM_REGS];
    end
  end

`ifdef WR_EN_DECODER_RR_ARB_EN
  // Next head: one past the highest-priority port that won a contested register.
  always_comb begin
    int best;
    best        = NUM_PORTS;
    win_found_s = 1'b0;
    ptr_next_s  = ptr_r;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept_s[p] && share_s[p] && (prio_rank(p, int'(ptr_r)) < best)) begin
        best        = prio_rank(p, int'(ptr_r));
        win_found_s = 1'b1;
        ptr_next_s  = PTR_W'((p + 1) % NUM_PORTS);
      end else begin
        best = best;
      end
    end
  end

  // Round-robin head register; moves only after a contested cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (win_found_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Enables and strobes register one cycle after acceptance; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_r <= '0;
      we_r <= '0;
    end else begin
      en_r <= dec_s;
      we_r <= we_s;
    end
  end

  // Saturating count of cycles with at least one stalled request; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (stall_any_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign req_ready    = ready_s;
  assign en_out       = en_r;
  assign we_any       = we_r;
  assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_wr_en_decoder_arb.sv
// Self-checking bench for wr_en_decoder_arb (2 ports, 32 registers, 4-bit counter).
// Honours WR_EN_DECODER_RR_ARB_EN for arbitration-dependent expectations.
module tb_wr_en_decoder_arb;

  localparam int NP = 2;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 4;
  localparam int EW = NP * NR;

  logic           clk = 1'b0;
  logic           reset;
  logic           cnt_clr;
  logic [NP-1:0]  req_valid;
  logic [NP-1:0]  req_ready;
  logic [NP*AW-1:0] req_addr;
  logic [EW-1:0]  en_out;
  logic [NR-1:0]  we_any;
  logic [CW-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state: what the DUT registers should hold after the next edge
  logic [EW-1:0] m_en;
  logic [NR-1:0] m_we;
  int            m_cnt;
  int            m_head;

  wr_en_decoder_arb #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .ZERO_REG  (1),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .en_out       (en_out),
    .we_any       (we_any),
    .cnt_clr      (cnt_clr),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  rdy;
    logic [63:0] en;
    logic [31:0] we;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
    req_valid = v;
    req_addr  = {a1, a0};
  endtask

  // reset for two edges, release at a falling edge
  task automatic do_reset();
    reset   = 1'b1;
    cnt_clr = 1'b0;
    drive(2'b00, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_en   = '0;
    m_we   = '0;
    m_cnt  = 0;
    m_head = 0;
  endtask

  // A valid port is ready unless an earlier port in the priority walk from head wants the same register.
  function automatic logic [NP-1:0] model_ready(input logic [NP-1:0] v, input logic [NP*AW-1:0] a, input int head);
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) begin
      r[p] = 1'b1;
      if (v[p]) begin
        for (int k = 0; k < NP; k++) begin
          int q;
          q = (head + k) % NP;
          if (q == p) break;
          if (v[q] && (a[q*AW +: AW] == a[p*AW +: AW])) r[p] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(input logic [NP-1:0] v, input logic [NP*AW-1:0] a, input logic clr,
                            output logic [NP-1:0] r);
    logic [EW-1:0] en;
    r  = model_ready(v, a, m_head);
    en = '0;
    for (int p = 0; p < NP; p++) begin
      if (v[p] && r[p] && (a[p*AW +: AW] != 5'd0)) en[p*NR + int'(a[p*AW +: AW])] = 1'b1;
    end
    m_en = en;
    m_we = en[NR-1:0] | en[EW-1:NR];
    if (clr) m_cnt = 0;
    else if (((v & ~r) != 2'b00) && (m_cnt < 15)) m_cnt = m_cnt + 1;
`ifdef WR_EN_DECODER_RR_ARB_EN
    begin
      int win;
      win = -1;
      for (int k = 0; k < NP; k++) begin
        int q;
        q = (m_head + k) % NP;
        if (win < 0 && v[q] && r[q]) begin
          for (int o = 0; o < NP; o++) begin
            if (o != q && v[o] && (a[o*AW +: AW] == a[q*AW +: AW])) win = q;
          end
        end
      end
      if (win >= 0) m_head = (win + 1) % NP;
    end
`endif
  endtask

  initial begin
    logic [NP-1:0]    rv;
    logic [NP*AW-1:0] ra;
    logic [NP-1:0]    er;
    logic [NP-1:0]    pst;
    logic             clr;
    logic [1:0]       rr_exp [4];

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("reset_en", en_out, 64'd0);
    check("reset_we", {32'd0, we_any}, 64'd0);
    check("reset_cnt", {60'd0, conflict_cnt}, 64'd0);

    // ---------------- table-driven single-cycle vectors ----------------
    tbl[0] = '{2'b11, 5'd3,  5'd9,  2'b11, 64'h0000_0200_0000_0008, 32'h0000_0208};
    tbl[1] = '{2'b01, 5'd31, 5'd0,  2'b11, 64'h0000_0000_8000_0000, 32'h8000_0000};
    tbl[2] = '{2'b10, 5'd4,  5'd0,  2'b11, 64'h0000_0000_0000_0000, 32'h0000_0000};
    tbl[3] = '{2'b00, 5'd5,  5'd5,  2'b11, 64'h0000_0000_0000_0000, 32'h0000_0000};
    tbl[4] = '{2'b11, 5'd0,  5'd1,  2'b11, 64'h0000_0002_0000_0000, 32'h0000_0002};
    tbl[5] = '{2'b11, 5'd17, 5'd18, 2'b11, 64'h0004_0000_0002_0000, 32'h0006_0000};
    tbl[6] = '{2'b10, 5'd9,  5'd5,  2'b11, 64'h0000_0020_0000_0000, 32'h0000_0020};
    tbl[7] = '{2'b11, 5'd12, 5'd12, 2'b01, 64'h0000_0000_0000_1000, 32'h0000_1000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1);
      #1;
      check($sformatf("tbl_ready[%0d]", i), {62'd0, req_ready}, {62'd0, tbl[i].rdy});
      @(posedge clk); #1;
      check($sformatf("tbl_en[%0d]", i), en_out, tbl[i].en);
      check($sformatf("tbl_we[%0d]", i), {32'd0, we_any}, {32'd0, tbl[i].we});
      @(negedge clk);
    end
    check("tbl_cnt", {60'd0, conflict_cnt}, 64'd1);

    // ---------------- async reset drops an in-flight enable ----------------
    do_reset();
    drive(2'b11, 5'd7, 5'd7);
    #1;
    check("rst_pre_ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    check("rst_pre_en", en_out, 64'd1 << 7);
    check("rst_pre_cnt", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);
    drive(2'b01, 5'd7, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_en", en_out, 64'd0);
    check("rst_async_we", {32'd0, we_any}, 64'd0);
    check("rst_async_cnt", {60'd0, conflict_cnt}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_post_en", en_out, 64'd0);
    check("rst_post_we", {32'd0, we_any}, 64'd0);
    check("rst_post_cnt", {60'd0, conflict_cnt}, 64'd0);
    @(negedge clk);

    // ---------------- same-address conflict held two cycles ----------------
    do_reset();
    drive(2'b11, 5'd12, 5'd12);
    #1;
    check("conf_c0_ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    check("conf_c0_en", en_out, 64'd1 << 12);
    check("conf_c0_cnt", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);
    drive(2'b10, 5'd12, 5'd12);
    #1;
    check("conf_c1_ready1", {63'd0, req_ready[1]}, 64'd1);
    @(posedge clk); #1;
    check("conf_c1_en", en_out, 64'd1 << 44);
    check("conf_c1_we", {32'd0, we_any}, 64'd1 << 12);
    check("conf_c1_cnt", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);

    // ---------------- zero register ----------------
    do_reset();
    drive(2'b01, 5'd0, 5'd0);
    #1;
    check("zero_ready", {62'd0, req_ready}, 64'd3);
    @(posedge clk); #1;
    check("zero_en", en_out, 64'd0);
    @(negedge clk);
    drive(2'b11, 5'd0, 5'd0);
    #1;
    check("zero_conf_ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    check("zero_conf_en", en_out, 64'd0);
    check("zero_conf_cnt", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);
    drive(2'b10, 5'd0, 5'd0);
    #1;
    check("zero_p1_ready", {63'd0, req_ready[1]}, 64'd1);
    @(posedge clk); #1;
    check("zero_p1_en", en_out, 64'd0);
    check("zero_p1_cnt", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);

    // ---------------- counter saturation and clear priority ----------------
    do_reset();
    drive(2'b11, 5'd4, 5'd4);
    repeat (15) @(posedge clk);
    #1;
    check("sat_cnt15", {60'd0, conflict_cnt}, 64'd15);
    repeat (5) @(posedge clk);
    #1;
    check("sat_cnt20", {60'd0, conflict_cnt}, 64'd15);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("clr_vs_conf", {60'd0, conflict_cnt}, 64'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    check("post_clr_inc", {60'd0, conflict_cnt}, 64'd1);
    @(negedge clk);

    // ---------------- persistent contention on one register ----------------
`ifdef WR_EN_DECODER_RR_ARB_EN
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 5'd5, 5'd5);
      #1;
      check($sformatf("arb_ready[%0d]", i), {62'd0, req_ready}, {62'd0, rr_exp[i]});
      @(posedge clk); #1;
      check($sformatf("arb_en[%0d]", i), en_out, (rr_exp[i] == 2'b01) ? (64'd1 << 5) : (64'd1 << 37));
      @(negedge clk);
    end

    // ---------------- randomized traffic against the reference model ----------------
    do_reset();
    pst = '0;
    rv  = '0;
    ra  = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pst[p]) begin
          rv[p] = ($urandom_range(0, 3) != 0);
          ra[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        end
      end
      clr       = ($urandom_range(0, 15) == 0);
      req_valid = rv;
      req_addr  = ra;
      cnt_clr   = clr;
      #1;
      model_step(rv, ra, clr, er);
      check($sformatf("rand_ready@%0d", c), {62'd0, req_ready}, {62'd0, er});
      @(posedge clk); #1;
      check($sformatf("rand_en@%0d", c), en_out, m_en);
      check($sformatf("rand_we@%0d", c), {32'd0, we_any}, {32'd0, m_we});
      check($sformatf("rand_cnt@%0d", c), {60'd0, conflict_cnt}, 64'(m_cnt));
      pst = rv & ~er;
      @(negedge clk);
    end
    cnt_clr = 1'b0;
    drive(2'b00, 5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
